bus_arbiter: RTL and testbench

- Two-master arbiter for the single SoC system bus.
- Master 0 is the CPU; master 1 is a DMA/loader engine, for example a frame-buffer filler or a UART boot loader.
- Outputs drive the existing slave-side bus signals: enable, wstrb, addr, wvalue and addr_prev.
- Routes the one-cycle-latency read data back to the master that issued the access. Supports bounded burst locking for master 1.

---
 rtl/bus_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master system-bus arbiter: CPU (master 0) and DMA/loader (master 1), with bounded burst lock for master 1.
// Define BUS_ARB_RR_EN for round-robin conflict resolution; otherwise master 0 has fixed priority.
module bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 8
) (
    input  logic        clk_i,
    input  logic        rstn,

    input  logic        m0_req_i,
    input  logic [3:0]  m0_wstrb_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wvalue_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rvalue_o,

    input  logic        m1_req_i,
    input  logic [3:0]  m1_wstrb_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wvalue_i,
    input  logic        m1_lock_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rvalue_o,

    output logic        bus_enable_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wvalue_o,
    output logic [31:0] bus_addr_prev_o,
    input  logic [31:0] bus_rvalue_i
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic             locked_q;
    logic [CNT_W-1:0] burst_cnt;
    logic             owner_q;
    logic             rd_pending_q;

    logic             lock_win;
    logic             base_pick1;
    logic             pick1;
    logic             accepted;

    // An expired lock (count at MAX_BURST) no longer overrides the base policy.
    assign lock_win = locked_q & m1_req_i & (burst_cnt < MAX_CNT);

`ifdef BUS_ARB_RR_EN
    logic last_q;

    assign base_pick1 = m1_req_i & (~m0_req_i | ~last_q);

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else if (accepted) begin
            last_q <= m1_gnt_o;
        end
    end
`else
    assign base_pick1 = m1_req_i & ~m0_req_i;
`endif

    assign pick1    = lock_win | base_pick1;
    assign m1_gnt_o = rstn & pick1;
    assign m0_gnt_o = rstn & m0_req_i & ~pick1;
    assign accepted = m0_gnt_o | m1_gnt_o;

    always_comb begin
        bus_enable_o = accepted;
        bus_wstrb_o  = 4'd0;
        bus_addr_o   = 32'd0;
        bus_wvalue_o = 32'd0;
        if (m1_gnt_o) begin
            bus_wstrb_o  = m1_wstrb_i;
            bus_addr_o   = m1_addr_i;
            bus_wvalue_o = m1_wvalue_i;
        end else if (m0_gnt_o) begin
            bus_wstrb_o  = m0_wstrb_i;
            bus_addr_o   = m0_addr_i;
            bus_wvalue_o = m0_wvalue_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            rd_pending_q    <= 1'b0;
            owner_q         <= 1'b0;
            bus_addr_prev_o <= 32'd0;
        end else begin
            rd_pending_q <= accepted & (bus_wstrb_o == 4'd0);
            owner_q      <= m1_gnt_o;
            if (accepted) begin
                bus_addr_prev_o <= bus_addr_o;
            end
        end
    end

    // Lock ends as soon as master 1 lets go of req or lock, or its burst budget is spent.
    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            locked_q  <= 1'b0;
            burst_cnt <= '0;
        end else if (!locked_q) begin
            if (m1_gnt_o && m1_lock_i) begin
                locked_q  <= 1'b1;
                burst_cnt <= CNT_W'(1);
            end
        end else if (!m1_req_i || !m1_lock_i || (burst_cnt >= MAX_CNT)) begin
            locked_q  <= 1'b0;
            burst_cnt <= '0;
        end else if (m1_gnt_o) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

    // Read data is gated by reset so an access aborted by reset never returns.
    assign m0_rvalid_o = rstn & rd_pending_q & ~owner_q;
    assign m1_rvalid_o = rstn & rd_pending_q & owner_q;
    assign m0_rvalue_o = m0_rvalid_o ? bus_rvalue_i : 32'd0;
    assign m1_rvalue_o = m1_rvalid_o ? bus_rvalue_i : 32'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: grants/bus mux checked in-cycle, read returns via a scoreboard queue.
// Expectations follow BUS_ARB_RR_EN when the bench is built with it.
module tb_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn  = 1'b0;
    logic        m0_req_i = 1'b0;
    logic [3:0]  m0_wstrb_i = 4'd0;
    logic [31:0] m0_addr_i = 32'd0;
    logic [31:0] m0_wvalue_i = 32'd0;
    logic        m0_gnt_o, m0_rvalid_o;
    logic [31:0] m0_rvalue_o;
    logic        m1_req_i = 1'b0;
    logic [3:0]  m1_wstrb_i = 4'd0;
    logic [31:0] m1_addr_i = 32'd0;
    logic [31:0] m1_wvalue_i = 32'd0;
    logic        m1_lock_i = 1'b0;
    logic        m1_gnt_o, m1_rvalid_o;
    logic [31:0] m1_rvalue_o;
    logic        bus_enable_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_addr_o, bus_wvalue_o, bus_addr_prev_o;
    logic [31:0] bus_rvalue_i = 32'd0;

    typedef struct {
        logic        rv0;
        logic        rv1;
        logic [31:0] prev;
    } resp_t;

    resp_t       sbQ[$];
    logic [31:0] modelPrev = 32'd0;
    int          checkCount = 0;
    int          passCount = 0;
    string       phase = "reset";

    always #5 clk_i = ~clk_i;

    bus_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
        .clk_i(clk_i), .rstn(rstn),
        .m0_req_i(m0_req_i), .m0_wstrb_i(m0_wstrb_i), .m0_addr_i(m0_addr_i),
        .m0_wvalue_i(m0_wvalue_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rvalue_o(m0_rvalue_o),
        .m1_req_i(m1_req_i), .m1_wstrb_i(m1_wstrb_i), .m1_addr_i(m1_addr_i),
        .m1_wvalue_i(m1_wvalue_i), .m1_lock_i(m1_lock_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rvalue_o(m1_rvalue_o),
        .bus_enable_o(bus_enable_o), .bus_wstrb_o(bus_wstrb_o), .bus_addr_o(bus_addr_o),
        .bus_wvalue_o(bus_wvalue_o), .bus_addr_prev_o(bus_addr_prev_o),
        .bus_rvalue_i(bus_rvalue_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s (%s): got 0x%08h, expected 0x%08h", tag, phase, actual, expected);
        end
    endtask

    // One bus cycle: drive after the edge, check mid-cycle, queue the next cycle's expected response.
    task automatic applyStimulus(
        input logic r0, input logic [3:0] s0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic [3:0] s1, input logic [31:0] a1, input logic [31:0] d1,
        input logic lk, input logic [31:0] rv, input int expGnt);
        resp_t       e;
        resp_t       n;
        logic [31:0] expAddr, expData;
        logic [3:0]  expStrb;
        @(posedge clk_i);
        #1;
        m0_req_i = r0; m0_wstrb_i = s0; m0_addr_i = a0; m0_wvalue_i = d0;
        m1_req_i = r1; m1_wstrb_i = s1; m1_addr_i = a1; m1_wvalue_i = d1;
        m1_lock_i = lk; bus_rvalue_i = rv;
        #4;
        if (sbQ.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbQ.pop_front();
            checkOutput("m0_rvalid", {31'd0, m0_rvalid_o}, {31'd0, e.rv0});
            checkOutput("m1_rvalid", {31'd0, m1_rvalid_o}, {31'd0, e.rv1});
            checkOutput("m0_rvalue", m0_rvalue_o, e.rv0 ? rv : 32'd0);
            checkOutput("m1_rvalue", m1_rvalue_o, e.rv1 ? rv : 32'd0);
            checkOutput("addr_prev", bus_addr_prev_o, e.prev);
        end
        expAddr = (expGnt == 1) ? a0 : (expGnt == 2) ? a1 : 32'd0;
        expData = (expGnt == 1) ? d0 : (expGnt == 2) ? d1 : 32'd0;
        expStrb = (expGnt == 1) ? s0 : (expGnt == 2) ? s1 : 4'd0;
        checkOutput("m0_gnt", {31'd0, m0_gnt_o}, {31'd0, expGnt == 1});
        checkOutput("m1_gnt", {31'd0, m1_gnt_o}, {31'd0, expGnt == 2});
        checkOutput("bus_enable", {31'd0, bus_enable_o}, {31'd0, expGnt != 0});
        checkOutput("bus_addr", bus_addr_o, expAddr);
        checkOutput("bus_wstrb", {28'd0, bus_wstrb_o}, {28'd0, expStrb});
        checkOutput("bus_wvalue", bus_wvalue_o, expData);
        if (expGnt != 0) modelPrev = expAddr;
        n.rv0  = (expGnt == 1) && (s0 == 4'd0);
        n.rv1  = (expGnt == 2) && (s1 == 4'd0);
        n.prev = modelPrev;
        sbQ.push_back(n);
    endtask

    // Holds reset with both masters requesting; nothing may be granted or returned.
    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i);
            #1;
            rstn = 1'b0;
            m0_req_i = 1'b1; m0_wstrb_i = 4'd0; m0_addr_i = 32'h1111_0000;
            m1_req_i = 1'b1; m1_wstrb_i = 4'd0; m1_addr_i = 32'h2222_0000;
            m1_lock_i = 1'b1; bus_rvalue_i = 32'h5A5A_5A5A;
            #4;
            checkOutput("rst_m0_gnt", {31'd0, m0_gnt_o}, 32'd0);
            checkOutput("rst_m1_gnt", {31'd0, m1_gnt_o}, 32'd0);
            checkOutput("rst_enable", {31'd0, bus_enable_o}, 32'd0);
            checkOutput("rst_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
            checkOutput("rst_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
            checkOutput("rst_m0_rvalue", m0_rvalue_o, 32'd0);
            if (i > 0) checkOutput("rst_addr_prev", bus_addr_prev_o, 32'd0);
        end
        @(posedge clk_i);
        #1;
        rstn = 1'b1;
        m0_req_i = 1'b0; m1_req_i = 1'b0; m1_lock_i = 1'b0;
        sbQ.delete();
        modelPrev = 32'd0;
        sbQ.push_back('{rv0: 1'b0, rv1: 1'b0, prev: 32'd0});
    endtask

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h8000_0000;

    initial begin
        phase = "reset";
        doReset(2);

        phase = "m0_read";
        applyStimulus(1, 4'h0, 32'h2000_0004, 0, 0, 4'h0, 0, 0, 0, 32'h0, 1);
        applyStimulus(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 0);

        phase = "conflict";
        doReset(1);
        for (int i = 0; i < 4; i++) begin
`ifdef BUS_ARB_RR_EN
            applyStimulus(1, 4'h0, A0, 0, 1, 4'h0, A1, 0, 0, 32'h1000 + i, (i % 2 == 0) ? 1 : 2);
`else
            applyStimulus(1, 4'h0, A0, 0, 1, 4'h0, A1, 0, 0, 32'h1000 + i, 1);
`endif
        end

        phase = "m1_write";
        applyStimulus(0, 4'h0, 0, 0, 1, 4'hF, 32'h8000_0100, 32'h00FF_00FF, 0, 32'h2000, 2);
        applyStimulus(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h3333_3333, 0);

        phase = "burst";
        doReset(1);
        applyStimulus(0, 4'h0, 0, 0, 1, 4'h0, 32'h9000_0000, 0, 1, 32'h0, 2);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1, 4'h0, A0, 0, 1, 4'h0, 32'h9000_0000 + 4 * i, 0, 1, 32'h4000 + i, 2);
        end
        applyStimulus(1, 4'h0, A0, 0, 1, 4'h0, 32'h9000_0010, 0, 1, 32'h4004, 1);
        applyStimulus(0, 4'h0, 0, 0, 1, 4'h0, 32'h9000_0010, 0, 1, 32'h4005, 2);
        applyStimulus(0, 4'h0, 0, 0, 1, 4'h0, 32'h9000_0014, 0, 1, 32'h4006, 2);
        applyStimulus(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h4007, 0);

        phase = "back2back";
        applyStimulus(1, 4'h0, 32'h3000_0008, 0, 0, 4'h0, 0, 0, 0, 32'h0, 1);
        applyStimulus(0, 4'h0, 0, 0, 1, 4'h3, 32'h8000_0200, 32'h1234_5678, 0, 32'hCAFE_F00D, 2);
        applyStimulus(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h7777_0000, 0);

        phase = "reset_mid_read";
        applyStimulus(1, 4'h0, 32'h4000_0000, 0, 0, 4'h0, 0, 0, 0, 32'h0, 1);
        doReset(2);
        applyStimulus(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 32'hBAD0_BAD0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
